// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_loader_pkg;

    // Loader phases: length field, data words, optional checksum, ack byte, core running.
    typedef enum logic [2:0] {
        LEN   = 3'd0,
        DATA  = 3'd1,
        CKSUM = 3'd2,
        ACK   = 3'd3,
        RUN   = 3'd4
    } state_t;

    localparam logic [7:0] ACK_OK  = 8'hAA;
    localparam logic [7:0] ACK_ERR = 8'hEE;

    // Ack byte reported to the host for a given error status.
    function automatic logic [7:0] ack_byte(input logic err);
        return err ? ACK_ERR : ACK_OK;
    endfunction

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Packs a byte stream into little-endian 32-bit words (first byte = bits 7:0).
// Latency: word/word_vld are combinational on the 4th byte's strobe.
// Backpressure: none; accepts a byte every cycle, clr restarts the byte count.
module word_assembler
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic [31:0] word,
    output logic        word_vld
);

    logic [1:0]  byte_cnt;
    logic [23:0] shreg;

    // Byte counter wraps 0..3; older bytes shift toward the low end.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_cnt <= 2'd0;
            shreg    <= 24'd0;
        end else if (clr) begin
            byte_cnt <= 2'd0;
        end else if (byte_vld) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {byte_dat, shreg[23:8]};
        end
    end

    // The 4th byte lands in the top lane, completing the word this cycle.
    always_comb begin
        word     = {byte_dat, shreg};
        word_vld = byte_vld && (byte_cnt == 2'd3) && !clr;
    end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: UART bytes -> length/words -> sequential instruction BRAM writes -> ack -> run.
// Latency: memory write registered one cycle after the 4th byte of a word; run one cycle after ack handshake.
// Backpressure: none on rx (bytes outside LEN/DATA/CKSUM dropped); tx_valid held until tx_ready.
// Build option: define INSTR_LOADER_CKSUM_EN to require a trailing XOR checksum word.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDRW = 10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        reload,
    input  logic [31:0] fetch_addr,
    output logic        run,
    output logic        load_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din
);

    state_t      state_q, state_d;
    logic [31:0] n_q, n_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] idx_inc;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic        txv_q, txv_d;
    logic [7:0]  txd_q, txd_d;
`ifdef INSTR_LOADER_CKSUM_EN
    logic [31:0] cks_q, cks_d;
`endif

    logic        asm_vld;
    logic        asm_clr;
    logic [31:0] word;
    logic        word_vld;
    logic        overflow;

    // Bytes are only assembled while a field is being collected; reload restarts the byte count.
    always_comb begin
        asm_vld  = rx_valid && (state_q == LEN || state_q == DATA || state_q == CKSUM);
        asm_clr  = (state_q == RUN) && reload;
        idx_inc  = idx_q + 32'd1;
        overflow = (idx_q >> ADDRW) != 32'd0;
    end

    word_assembler u_asm (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (asm_clr),
        .byte_vld (asm_vld),
        .byte_dat (rx_data),
        .word     (word),
        .word_vld (word_vld)
    );

    // All loader state and the registered memory/tx outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= LEN;
            n_q     <= 32'd0;
            idx_q   <= 32'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            din_q   <= 32'd0;
            txv_q   <= 1'b0;
            txd_q   <= 8'h00;
`ifdef INSTR_LOADER_CKSUM_EN
            cks_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            txv_q   <= txv_d;
            txd_q   <= txd_d;
`ifdef INSTR_LOADER_CKSUM_EN
            cks_q   <= cks_d;
`endif
        end
    end

    // Next-state logic; write strobe defaults low so each write is a single-cycle pulse.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        txv_d   = txv_q;
        txd_d   = txd_q;
`ifdef INSTR_LOADER_CKSUM_EN
        cks_d   = cks_q;
`endif
        case (state_q)
            LEN: begin
                if (word_vld) begin
                    n_d   = word;
                    idx_d = 32'd0;
`ifdef INSTR_LOADER_CKSUM_EN
                    cks_d = 32'd0;
`endif
                    if (word == 32'd0) begin
`ifdef INSTR_LOADER_CKSUM_EN
                        state_d = CKSUM;
`else
                        // Nothing to write: the ack goes out the very next cycle.
                        state_d = ACK;
                        txv_d   = 1'b1;
                        txd_d   = ack_byte(err_q);
`endif
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (word_vld) begin
`ifdef INSTR_LOADER_CKSUM_EN
                    cks_d = cks_q ^ word;
`endif
                    // Words past the end of memory are swallowed and flagged.
                    if (overflow) begin
                        err_d = 1'b1;
                    end else begin
                        we_d   = 1'b1;
                        addr_d = {idx_q[29:0], 2'b00};
                        din_d  = word;
                    end
                    idx_d = idx_inc;
                    if (idx_inc == n_q) begin
`ifdef INSTR_LOADER_CKSUM_EN
                        state_d = CKSUM;
`else
                        state_d = ACK;
`endif
                    end
                end
            end
`ifdef INSTR_LOADER_CKSUM_EN
            CKSUM: begin
                if (word_vld) begin
                    if (word != cks_q) begin
                        err_d = 1'b1;
                    end
                    state_d = ACK;
                    txv_d   = 1'b1;
                    txd_d   = ack_byte(err_d);
                end
            end
`endif
            ACK: begin
                // Entered from DATA with tx idle: raise the ack one cycle after the last write.
                if (txv_q) begin
                    if (tx_ready) begin
                        txv_d   = 1'b0;
                        state_d = RUN;
                    end
                end else begin
                    txv_d = 1'b1;
                    txd_d = ack_byte(err_q);
                end
            end
            RUN: begin
                if (reload) begin
                    state_d = LEN;
                    err_d   = 1'b0;
                    idx_d   = 32'd0;
                    n_d     = 32'd0;
                end
            end
            default: begin
                state_d = LEN;
            end
        endcase
    end

    // In RUN the fetch stage owns the memory port directly.
    always_comb begin
        run      = (state_q == RUN);
        mem_we   = we_q;
        mem_addr = run ? fetch_addr : addr_q;
        mem_din  = din_q;
        tx_valid = txv_q;
        tx_data  = txd_q;
        load_err = err_q;
    end

endmodule
